// File: rtl/fetch_prefetch.sv
// ---------------------------------------------------------------------------
// fetch_prefetch
//
// Instruction fetch unit with a prefetch FIFO. It owns the fetch PC and
// streams sequential reads to a synchronous instruction memory (1-cycle read
// latency, halfword addressed). Each response is pushed into a FIFO_DEPTH-entry
// buffer that feeds decode. A redirect flushes the buffer, drops any read in
// flight and restarts fetch at redirect_addr_i.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : a response that arrives while the FIFO is empty is presented
//               straight to decode in the same cycle (latency 1).
//   undefined : every instruction goes through the FIFO (latency 2).
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   fetch_en_i       permit new memory reads
//   redirect_valid_i flush and restart at redirect_addr_i
//   redirect_addr_i  new fetch PC
//   mem_addr_o       read address (the PC register)
//   mem_en_o         memory enable, high only in an issue cycle
//   mem_rd_en_o      copy of mem_en_o
//   mem_wr_en_o      tied low
//   mem_dout_i       read data, valid the cycle after an issue
//   instr_o          head instruction
//   instr_pc_o       address of instr_o
//   instr_valid_o    instr_o / instr_pc_o valid
//   instr_ready_i    decode accepts
//   dbg_state_o      FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a transfer to decode happens on a rising edge where
// instr_valid_o and instr_ready_i are both high. While instr_valid_o is high
// and instr_ready_i is low, instr_o and instr_pc_o hold stable. instr_valid_o
// never depends on instr_ready_i.
// ---------------------------------------------------------------------------
module fetch_prefetch #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          INSTR_WIDTH = 16,
  parameter int          FIFO_DEPTH  = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fetch_en_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic                   mem_en_o,
  output logic                   mem_rd_en_o,
  output logic                   mem_wr_en_o,
  input  logic [INSTR_WIDTH-1:0] mem_dout_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic                   dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;

  logic [INSTR_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_q    [FIFO_DEPTH];

  logic                   fifo_empty;
  logic [CNT_W:0]         occupancy;
  logic                   issue;
  logic                   resp_live;
  logic                   bypass;
  logic                   pop;
  logic                   fifo_pop;
  logic                   fifo_push;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    // A pop in the same cycle is deliberately not credited, which keeps
    // instr_ready_i out of the mem_en_o cone.
    occupancy  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
    issue      = (state_q == RUN) & fetch_en_i & (occupancy < DEPTH_OCC)
                 & ~redirect_valid_i;
    // A response landing in a redirect cycle belongs to the old stream.
    resp_live  = inflight_q & ~redirect_valid_i;
`ifdef FETCH_BYPASS_EN
    bypass     = resp_live & fifo_empty;
`else
    bypass     = 1'b0;
`endif

    instr_o       = '0;
    instr_pc_o    = '0;
    if (bypass) begin
      instr_o    = mem_dout_i;
      instr_pc_o = resp_pc_q;
    end else if (!fifo_empty) begin
      instr_o    = fifo_instr_q[rd_ptr_q];
      instr_pc_o = fifo_pc_q[rd_ptr_q];
    end
    instr_valid_o = (~fifo_empty | bypass) & ~redirect_valid_i;

    pop       = instr_valid_o & instr_ready_i;
    fifo_pop  = pop & ~fifo_empty;
    // A bypassed response that decode takes immediately never enters the FIFO.
    fifo_push = resp_live & ~(bypass & instr_ready_i);

    pc_d       = pc_q;
    inflight_d = issue;
    resp_pc_d  = resp_pc_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid_i) begin
      pc_d     = redirect_addr_i;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d      = pc_q + ADDR_WIDTH'(1);
        resp_pc_d = pc_q;
      end
      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      inflight_q <= 1'b0;
      resp_pc_q  <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en_i)  state_q <= RUN;
        RUN:     if (!fetch_en_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      resp_pc_q  <= resp_pc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read when counted as occupied.
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_instr_q[wr_ptr_q] <= mem_dout_i;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  assign mem_addr_o  = pc_q;
  assign mem_en_o    = issue;
  assign mem_rd_en_o = issue;
  assign mem_wr_en_o = 1'b0;
  assign dbg_state_o = state_q;

  // Issue throttling makes a push into a full FIFO impossible.
  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && (cnt_q == DEPTH_CNT) && !fifo_pop));

endmodule
